// File: rtl/sos_pkg.sv
// Shared definitions for the SOS cascade sequencer: coefficient selects, FSM states, unity gain.
package sos_pkg;

  localparam logic [2:0] SEL_B0   = 3'd0;
  localparam logic [2:0] SEL_B1   = 3'd1;
  localparam logic [2:0] SEL_B2   = 3'd2;
  localparam logic [2:0] SEL_A1   = 3'd3;
  localparam logic [2:0] SEL_A2   = 3'd4;
  localparam logic [2:0] SEL_GAIN = 3'd5;
  localparam int NUM_SEL = 6;

  // Q2.18 representation of 1.0
  localparam int unsigned UNITY_COEF = 32'd262144;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  function automatic int stg_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sos_eng_if.sv
// Handshake and coefficient bundle between the cascade sequencer (master) and the shared biquad engine (slave).
interface sos_eng_if #(
  parameter int DATA_SIZE = 24,
  parameter int COEF_SIZE = 20,
  parameter int STG_W     = 1
);
  logic                 eng_start;
  logic [STG_W-1:0]     eng_stage;
  logic [DATA_SIZE-1:0] eng_data_in;
  logic [COEF_SIZE-1:0] eng_b0, eng_b1, eng_b2, eng_a1, eng_a2, eng_gain;
  logic                 eng_done;
  logic [DATA_SIZE-1:0] eng_data_out;

  modport master (
    output eng_start, eng_stage, eng_data_in,
    output eng_b0, eng_b1, eng_b2, eng_a1, eng_a2, eng_gain,
    input  eng_done, eng_data_out
  );

  modport slave (
    input  eng_start, eng_stage, eng_data_in,
    input  eng_b0, eng_b1, eng_b2, eng_a1, eng_a2, eng_gain,
    output eng_done, eng_data_out
  );
endinterface

// File: rtl/sos_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank, a commit copies every stage to the active bank.
module sos_coef_bank
  import sos_pkg::*;
#(
  parameter int COEF_SIZE  = 20,
  parameter int NUM_STAGES = 2,
  parameter int STG_W      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [STG_W-1:0]     cfg_stage,
  input  logic [2:0]           cfg_sel,
  input  logic [COEF_SIZE-1:0] cfg_data,
  input  logic                 commit,
  input  logic [STG_W-1:0]     rd_stage,
  output logic [COEF_SIZE-1:0] b0,
  output logic [COEF_SIZE-1:0] b1,
  output logic [COEF_SIZE-1:0] b2,
  output logic [COEF_SIZE-1:0] a1,
  output logic [COEF_SIZE-1:0] a2,
  output logic [COEF_SIZE-1:0] gain
);

  localparam logic [COEF_SIZE-1:0] UNITY_C = COEF_SIZE'(UNITY_COEF);

  logic [COEF_SIZE-1:0] shadow_r   [NUM_STAGES][NUM_SEL];
  logic [COEF_SIZE-1:0] shadow_n_s [NUM_STAGES][NUM_SEL];
  logic [COEF_SIZE-1:0] active_r   [NUM_STAGES][NUM_SEL];
  logic                 wr_ok_s;

  assign wr_ok_s = cfg_we && (32'(cfg_stage) < NUM_STAGES) && (cfg_sel <= SEL_GAIN);

  // Shadow image including this cycle's write, so a same-cycle commit picks it up
  always_comb begin
    shadow_n_s = shadow_r;
    if (wr_ok_s) begin
      shadow_n_s[cfg_stage][cfg_sel] = cfg_data;
    end else begin
      shadow_n_s = shadow_r;
    end
  end

  // Shadow bank register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        for (int k = 0; k < NUM_SEL; k++) shadow_r[s][k] <= '0;
        shadow_r[s][SEL_B0]   <= UNITY_C;
        shadow_r[s][SEL_GAIN] <= UNITY_C;
      end
    end else begin
      shadow_r <= shadow_n_s;
    end
  end

  // Active bank, refreshed as a whole on commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        for (int k = 0; k < NUM_SEL; k++) active_r[s][k] <= '0;
        active_r[s][SEL_B0]   <= UNITY_C;
        active_r[s][SEL_GAIN] <= UNITY_C;
      end
    end else if (commit) begin
      active_r <= shadow_n_s;
    end
  end

  assign b0   = active_r[rd_stage][SEL_B0];
  assign b1   = active_r[rd_stage][SEL_B1];
  assign b2   = active_r[rd_stage][SEL_B2];
  assign a1   = active_r[rd_stage][SEL_A1];
  assign a2   = active_r[rd_stage][SEL_A2];
  assign gain = active_r[rd_stage][SEL_GAIN];

endmodule

// File: rtl/sos_cascade_sequencer.sv
// Runs each sample through NUM_STAGES passes of one shared biquad engine with run-time retunable coefficients.
// Optional WAIT watchdog with sticky eng_timeout output is enabled by defining SOS_TIMEOUT_EN.
module sos_cascade_sequencer
  import sos_pkg::*;
#(
  parameter int COEF_SIZE   = 20,
  parameter int DATA_SIZE   = 24,
  parameter int NUM_STAGES  = 2,
  parameter int TIMEOUT_CYC = 255,
  localparam int STG_W      = stg_width(NUM_STAGES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_trig,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 overrun,
`ifdef SOS_TIMEOUT_EN
  output logic                 eng_timeout,
`endif
  input  logic                 cfg_we,
  input  logic [STG_W-1:0]     cfg_stage,
  input  logic [2:0]           cfg_sel,
  input  logic [COEF_SIZE-1:0] cfg_data,
  input  logic                 cfg_commit,
  sos_eng_if.master            eng
);

  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);

  state_e               state_r, state_n_s;
  logic [DATA_SIZE-1:0] acc_r, data_out_r;
  logic [STG_W-1:0]     stage_r;
  logic                 data_valid_r, busy_r, overrun_r, eng_start_r, commit_pend_r;
  logic                 eng_start_s, busy_s, data_valid_s, commit_copy_s, timeout_hit_s;
  logic [COEF_SIZE-1:0] b0_s, b1_s, b2_s, a1_s, a2_s, gain_s;

`ifdef SOS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_r;
  logic            timeout_r;

  assign timeout_hit_s = (state_r == ST_WAIT) && !eng.eng_done && (wd_r == WD_LAST);
  assign eng_timeout   = timeout_r;

  // WAIT watchdog and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_r      <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (state_r == ST_WAIT && !eng.eng_done) wd_r <= wd_r + WD_W'(1);
      else                                     wd_r <= '0;
      if (timeout_hit_s) timeout_r <= 1'b1;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // A pending commit is served on the first IDLE cycle, ahead of the sample it may coincide with
  assign commit_copy_s = (state_r == ST_IDLE) && (commit_pend_r || (cfg_commit && !sample_trig));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_n_s;
  end

  // Next-state logic
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sample_trig) state_n_s = ST_ISSUE;
        else             state_n_s = ST_IDLE;
      end
      ST_ISSUE: state_n_s = ST_WAIT;
      ST_WAIT: begin
        if (eng.eng_done) begin
          if (stage_r == LAST_STAGE) state_n_s = ST_OUT;
          else                       state_n_s = ST_ISSUE;
        end else if (timeout_hit_s) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_WAIT;
        end
      end
      ST_OUT:  state_n_s = ST_IDLE;
      default: state_n_s = ST_IDLE;
    endcase
  end

  // FSM outputs, registered below so they line up with the state they describe
  always_comb begin
    eng_start_s  = (state_n_s == ST_ISSUE);
    busy_s       = (state_n_s != ST_IDLE);
    data_valid_s = (state_r == ST_OUT);
  end

  // Datapath, flags and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r         <= '0;
      data_out_r    <= '0;
      stage_r       <= '0;
      data_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
      eng_start_r   <= 1'b0;
      commit_pend_r <= 1'b0;
    end else begin
      eng_start_r  <= eng_start_s;
      busy_r       <= busy_s;
      data_valid_r <= data_valid_s;
      if (sample_trig && state_r != ST_IDLE) overrun_r <= 1'b1;
      if (cfg_commit && !(state_r == ST_IDLE && !sample_trig)) commit_pend_r <= 1'b1;
      else if (commit_copy_s)                                  commit_pend_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sample_trig) begin
            acc_r   <= data_in;
            stage_r <= '0;
          end
        end
        ST_WAIT: begin
          if (eng.eng_done) begin
            acc_r <= eng.eng_data_out;
            if (stage_r != LAST_STAGE) stage_r <= stage_r + STG_W'(1);
          end
        end
        ST_OUT: begin
          data_out_r <= acc_r;
          stage_r    <= '0;
        end
        default: ;
      endcase
    end
  end

  sos_coef_bank #(
    .COEF_SIZE (COEF_SIZE),
    .NUM_STAGES(NUM_STAGES),
    .STG_W     (STG_W)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_stage(cfg_stage),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .commit   (commit_copy_s),
    .rd_stage (stage_r),
    .b0       (b0_s),
    .b1       (b1_s),
    .b2       (b2_s),
    .a1       (a1_s),
    .a2       (a2_s),
    .gain     (gain_s)
  );

  assign eng.eng_start   = eng_start_r;
  assign eng.eng_stage   = stage_r;
  assign eng.eng_data_in = acc_r;
  assign eng.eng_b0      = b0_s;
  assign eng.eng_b1      = b1_s;
  assign eng.eng_b2      = b2_s;
  assign eng.eng_a1      = a1_s;
  assign eng.eng_a2      = a2_s;
  assign eng.eng_gain    = gain_s;

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_sos_cascade_sequencer.sv
// Directed bench for sos_cascade_sequencer with a 3-cycle "out = in + 1" engine model.
module tb_sos_cascade_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_trig;
  logic [23:0] data_in;
  logic [23:0] data_out;
  logic        data_valid, busy, overrun;
`ifdef SOS_TIMEOUT_EN
  logic        eng_timeout;
`endif
  logic        cfg_we;
  logic [0:0]  cfg_stage;
  logic [2:0]  cfg_sel;
  logic [19:0] cfg_data;
  logic        cfg_commit;
  logic        hang;

  int          n_pass  = 0;
  int          n_total = 0;
  int          n_starts;
  logic [0:0]  st_log [8];
  logic [19:0] b0_log [8];

  always #5 clk = ~clk;

  sos_eng_if #(.DATA_SIZE(24), .COEF_SIZE(20), .STG_W(1)) eng ();

  sos_cascade_sequencer #(
    .COEF_SIZE(20), .DATA_SIZE(24), .NUM_STAGES(2), .TIMEOUT_CYC(255)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_trig(sample_trig),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun),
`ifdef SOS_TIMEOUT_EN
    .eng_timeout(eng_timeout),
`endif
    .cfg_we     (cfg_we),
    .cfg_stage  (cfg_stage),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .eng        (eng)
  );

  // Engine model: done three cycles after start, result = input + 1
  logic        p1, p2, p3;
  logic [23:0] cap;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1 <= 1'b0; p2 <= 1'b0; p3 <= 1'b0; cap <= 24'd0;
    end else begin
      p1 <= eng.eng_start;
      p2 <= p1;
      p3 <= p2 && !hang;
      if (eng.eng_start) cap <= eng.eng_data_in + 24'd1;
    end
  end
  assign eng.eng_done     = p3;
  assign eng.eng_data_out = cap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int start_cyc, output int cyc);
    cyc = start_cyc;
    while (data_valid !== 1'b1 && cyc < 60) begin
      if (eng.eng_start === 1'b1 && n_starts < 8) begin
        st_log[n_starts] = eng.eng_stage;
        b0_log[n_starts] = eng.eng_b0;
        n_starts++;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic do_sample(input logic [23:0] din, output int cyc);
    data_in     = din;
    sample_trig = 1'b1;
    n_starts    = 0;
    tick();
    sample_trig = 1'b0;
    wait_valid(1, cyc);
  endtask

  task automatic test_reset();
    reset = 1'b0; sample_trig = 1'b0; data_in = 24'd0; hang = 1'b0;
    cfg_we = 1'b0; cfg_stage = 1'b0; cfg_sel = 3'd0; cfg_data = 20'd0; cfg_commit = 1'b0;
    tick(); tick();
    n_total++; if (data_out !== 24'd0)   $display("FAIL reset_data_out got %0d want 0", data_out); else n_pass++;
    n_total++; if (data_valid !== 1'b0)  $display("FAIL reset_data_valid got %0b want 0", data_valid); else n_pass++;
    n_total++; if (busy !== 1'b0)        $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_total++; if (overrun !== 1'b0)     $display("FAIL reset_overrun got %0b want 0", overrun); else n_pass++;
    n_total++; if (eng.eng_start !== 1'b0 || eng.eng_stage !== 1'b0)
      $display("FAIL reset_eng_ctl got start=%0b stage=%0d want 0/0", eng.eng_start, eng.eng_stage); else n_pass++;
    n_total++; if (eng.eng_b0 !== 20'd262144)   $display("FAIL reset_b0 got %0d want 262144", eng.eng_b0); else n_pass++;
    n_total++; if (eng.eng_gain !== 20'd262144) $display("FAIL reset_gain got %0d want 262144", eng.eng_gain); else n_pass++;
    n_total++; if ((eng.eng_b1 | eng.eng_b2 | eng.eng_a1 | eng.eng_a2) !== 20'd0)
      $display("FAIL reset_coef_zero got b1=%0d b2=%0d a1=%0d a2=%0d want 0", eng.eng_b1, eng.eng_b2, eng.eng_a1, eng.eng_a2); else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int cyc;
    do_sample(24'd100, cyc);
    n_total++; if (cyc !== 10)            $display("FAIL t1_latency got %0d want 10", cyc); else n_pass++;
    n_total++; if (data_out !== 24'd102)  $display("FAIL t1_data_out got %0d want 102", data_out); else n_pass++;
    n_total++; if (n_starts !== 2)        $display("FAIL t1_starts got %0d want 2", n_starts); else n_pass++;
    n_total++; if (st_log[0] !== 1'b0 || st_log[1] !== 1'b1)
      $display("FAIL t1_stage_order got %0d,%0d want 0,1", st_log[0], st_log[1]); else n_pass++;
    n_total++; if (busy !== 1'b0)         $display("FAIL t1_busy_after got %0b want 0", busy); else n_pass++;
    tick();
    n_total++; if (data_valid !== 1'b0 || data_out !== 24'd102)
      $display("FAIL t1_hold got valid=%0b out=%0d want 0/102", data_valid, data_out); else n_pass++;
  endtask

  task automatic test_overrun();
    int cyc;
    data_in = 24'd100; sample_trig = 1'b1;
    tick();
    data_in = 24'd500;
    n_total++; if (busy !== 1'b1) $display("FAIL t2_busy got %0b want 1", busy); else n_pass++;
    tick();
    sample_trig = 1'b0;
    n_total++; if (overrun !== 1'b1) $display("FAIL t2_overrun_set got %0b want 1", overrun); else n_pass++;
    n_starts = 0;
    wait_valid(2, cyc);
    n_total++; if (cyc !== 10 || data_out !== 24'd102)
      $display("FAIL t2_first_sample got cyc=%0d out=%0d want 10/102", cyc, data_out); else n_pass++;
    do_sample(24'd7, cyc);
    n_total++; if (data_out !== 24'd9 || cyc !== 10)
      $display("FAIL t2_next_sample got out=%0d cyc=%0d want 9/10", data_out, cyc); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL t2_overrun_sticky got %0b want 1", overrun); else n_pass++;
  endtask

  task automatic test_commit_busy();
    int cyc;
    data_in = 24'd10; sample_trig = 1'b1;
    tick();
    sample_trig = 1'b0;
    cfg_we = 1'b1; cfg_stage = 1'b1; cfg_sel = 3'd0; cfg_data = 20'h30000; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    n_starts = 0;
    wait_valid(2, cyc);
    n_total++; if (n_starts !== 1 || st_log[0] !== 1'b1 || b0_log[0] !== 20'd262144)
      $display("FAIL t3_b0_this_sample got n=%0d stage=%0d b0=%0d want 1/1/262144", n_starts, st_log[0], b0_log[0]); else n_pass++;
    n_total++; if (data_out !== 24'd12) $display("FAIL t3_out1 got %0d want 12", data_out); else n_pass++;
    do_sample(24'd20, cyc);
    n_total++; if (n_starts !== 2 || b0_log[0] !== 20'd262144 || b0_log[1] !== 20'd196608)
      $display("FAIL t3_b0_next_sample got n=%0d b0s=%0d,%0d want 2/262144,196608", n_starts, b0_log[0], b0_log[1]); else n_pass++;
    n_total++; if (data_out !== 24'd22) $display("FAIL t3_out2 got %0d want 22", data_out); else n_pass++;
  endtask

  task automatic test_cfg_guard();
    cfg_we = 1'b1; cfg_stage = 1'b0; cfg_sel = 3'd6; cfg_data = 20'h12345;
    tick();
    cfg_sel = 3'd7;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    n_total++; if (eng.eng_b0 !== 20'd262144 || eng.eng_gain !== 20'd262144 ||
                   (eng.eng_b1 | eng.eng_b2 | eng.eng_a1 | eng.eng_a2) !== 20'd0)
      $display("FAIL t4_bad_sel got b0=%0d b1=%0d b2=%0d a1=%0d a2=%0d g=%0d want unity", eng.eng_b0,
               eng.eng_b1, eng.eng_b2, eng.eng_a1, eng.eng_a2, eng.eng_gain); else n_pass++;
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_data = 20'h00555;
    tick();
    cfg_we = 1'b0;
    tick();
    n_total++; if (eng.eng_b1 !== 20'd0) $display("FAIL t4_shadow_only got %0d want 0", eng.eng_b1); else n_pass++;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n_total++; if (eng.eng_b1 !== 20'h00555) $display("FAIL t4_idle_commit got %0h want 555", eng.eng_b1); else n_pass++;
    cfg_we = 1'b1; cfg_commit = 1'b1; cfg_sel = 3'd3; cfg_data = 20'h00123;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    n_total++; if (eng.eng_a1 !== 20'h00123) $display("FAIL t4_write_commit_same got %0h want 123", eng.eng_a1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    int vcnt;
    data_in = 24'd50; sample_trig = 1'b1;
    tick();
    sample_trig = 1'b0;
    repeat (5) tick();
    n_total++; if (eng.eng_stage !== 1'b1 || busy !== 1'b1)
      $display("FAIL t5_pre got stage=%0d busy=%0b want 1/1", eng.eng_stage, busy); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL t5_busy got %0b want 0", busy); else n_pass++;
    tick();
    reset = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (data_valid === 1'b1) vcnt++;
      tick();
    end
    n_total++; if (vcnt !== 0) $display("FAIL t5_no_valid got %0d pulses want 0", vcnt); else n_pass++;
    n_total++; if (eng.eng_a1 !== 20'd0 || data_out !== 24'd0 || overrun !== 1'b0)
      $display("FAIL t5_cleared got a1=%0d out=%0d ovr=%0b want 0/0/0", eng.eng_a1, data_out, overrun); else n_pass++;
    do_sample(24'd60, cyc);
    n_total++; if (data_out !== 24'd62 || cyc !== 10)
      $display("FAIL t5_recover got out=%0d cyc=%0d want 62/10", data_out, cyc); else n_pass++;
  endtask

`ifdef SOS_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    int vseen;
    hang = 1'b1;
    data_in = 24'd70; sample_trig = 1'b1;
    tick();
    sample_trig = 1'b0;
    cyc = 1;
    vseen = 0;
    while (busy !== 1'b0 && cyc < 400) begin
      if (data_valid === 1'b1) vseen++;
      tick();
      cyc++;
    end
    n_total++; if (cyc !== 257) $display("FAIL t6_abort_cycle got %0d want 257", cyc); else n_pass++;
    n_total++; if (eng_timeout !== 1'b1) $display("FAIL t6_timeout got %0b want 1", eng_timeout); else n_pass++;
    n_total++; if (data_out !== 24'd62 || vseen !== 0)
      $display("FAIL t6_no_output got out=%0d pulses=%0d want 62/0", data_out, vseen); else n_pass++;
    hang = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_commit_busy();
    test_cfg_guard();
    test_reset_mid();
`ifdef SOS_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
